// File: rtl/seq_divider_8by4_pkg.sv
// Shared constants and FSM state type for the 8b/4b sequential restoring divider.
package seq_divider_8by4_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;
    localparam int unsigned CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Operand/result valid-ready bundle between a requester (master) and the divider (slave).
interface seq_divider_8by4_if;
    import seq_divider_8by4_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_8by4_trial.sv
// Trial subtractor a - b computed as a + ~b + 1 through a Kogge-Stone prefix carry network.
module seq_divider_8by4_trial #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    localparam int unsigned Levels = $clog2(W);

    logic [W-1:0] nb;
    logic [W-1:0] p_bit;
    logic [W-1:0] g [Levels+1];
    logic [W-1:0] p [Levels+1];

    assign nb    = ~b_i;
    assign p_bit = a_i ^ nb;
    // Carry-in of 1 is folded into bit 0's generate, so every group ending at bit 0 is a carry.
    assign g[0]  = (a_i & nb) | {{(W-1){1'b0}}, p_bit[0]};
    assign p[0]  = p_bit;

    for (genvar l = 0; l < Levels; l++) begin : g_level
        localparam int unsigned D = 2 ** l;
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= D) begin : g_cell
                // Black cell where the span stays above bit 0, grey otherwise (its P is dead).
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
                assign p[l+1][i] = p[l][i] & p[l][i-D];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end

    assign diff_o   = p_bit ^ {g[Levels][W-2:0], 1'b1};
    assign borrow_o = ~g[Levels][W-1];

endmodule

// File: rtl/seq_divider_8by4.sv
// Restoring divider: one quotient bit per clock, valid/ready on both operand and result sides.
module seq_divider_8by4
    import seq_divider_8by4_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    seq_divider_8by4_if.slave  bus
);

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [DW-1:0] dvd_q;
    logic [DW-1:0] quot_q;
    logic [VW-1:0] dvs_q;
    logic [VW:0]   rem_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          dbz_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;

    logic [VW:0]   rem_shift;
    logic [VW:0]   trial_diff;
    logic          trial_borrow;
    logic [VW:0]   rem_d;
    logic [DW-1:0] quot_d;

    always_comb begin
        rem_shift = {rem_q[VW-1:0], dvd_q[DW-1]};
        rem_d     = trial_borrow ? rem_shift : trial_diff;
        quot_d    = {quot_q[DW-2:0], ~trial_borrow};
    end

    seq_divider_8by4_trial #(
        .W (VW + 1)
    ) u_trial (
        .a_i      (rem_shift),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            dvd_q       <= '0;
            quot_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        dvd_q      <= bus.dividend;
                        dvs_q      <= bus.divisor;
                        rem_q      <= '0;
                        quot_q     <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            count_q <= CW'(DW);
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    rem_q   <= rem_d;
                    quot_q  <= quot_d;
                    dvd_q   <= dvd_q << 1;
                    count_q <= count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        quotient_q  <= quot_d;
                        remainder_q <= rem_d[VW-1:0];
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4: directed table, corner sequences, random and sweep.
module tb_seq_divider_8by4;
    import seq_divider_8by4_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_8by4_if bus ();

    seq_divider_8by4 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    task automatic model(input logic [7:0] n, input logic [3:0] d,
                         output logic [7:0] q, output logic [3:0] r, output logic dbz);
        if (d == 0) begin
            q = 8'hFF;
            r = 4'h0;
            dbz = 1'b1;
        end else begin
            q = 8'(int'(n) / int'(d));
            r = 4'(int'(n) % int'(d));
            dbz = 1'b0;
        end
    endtask

    // Issue one operation and consume its result; lat = cycles from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs, input bit rand_rdy,
                         output logic [7:0] q, output logic [3:0] r, output logic dbz,
                         output int lat);
        int  w;
        bit  hs;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        tick;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick;
            lat++;
        end
        q   = bus.quotient;
        r   = bus.remainder;
        dbz = bus.div_by_zero;
        if (bus.out_valid !== 1'b1) begin
            lat = -1;
            return;
        end
        w = 0;
        hs = 1'b0;
        while (!hs) begin
            bus.out_ready = (rand_rdy && w < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = bus.out_ready;
            tick;
            w++;
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [7:0] q, mq;
        logic [3:0] r, mr;
        logic       dbz, mdbz;
        int         lat;
        int         w;

        vecs[0] = '{dvd: 8'd143, dvs: 4'd11, q: 8'd13,  r: 4'd0, dbz: 1'b0, lat: 9};
        vecs[1] = '{dvd: 8'd200, dvs: 4'd15, q: 8'd13,  r: 4'd5, dbz: 1'b0, lat: 9};
        vecs[2] = '{dvd: 8'd7,   dvs: 4'd9,  q: 8'd0,   r: 4'd7, dbz: 1'b0, lat: 9};
        vecs[3] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0, lat: 9};
        vecs[4] = '{dvd: 8'd42,  dvs: 4'd0,  q: 8'hFF,  r: 4'd0, dbz: 1'b1, lat: 1};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", bus.div_by_zero, 0);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, 1'b0, q, r, dbz, lat);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_post_valid", i), bus.out_valid, 0);
            check($sformatf("vec%0d_post_ready", i), bus.in_ready, 1);
        end

        // Backpressure on 100/7 with ignored operands presented during DONE
        bus.dividend = 8'd100;
        bus.divisor  = 4'd7;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        w = 1;
        while (bus.out_valid !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        check("bp_latency", w, 9);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
            tick;
            check("bp_hold_q", bus.quotient, 14);
            check("bp_hold_r", bus.remainder, 2);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("bp_drop_valid", bus.out_valid, 0);
        check("bp_idle_ready", bus.in_ready, 1);
        tick;
        tick;
        check("bp_no_queued_op", bus.out_valid, 0);

        // Reset in the 4th RUN cycle of 250/3
        bus.dividend = 8'd250;
        bus.divisor  = 4'd3;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 10; i++) tick;
        check("abort_stays_idle", bus.out_valid, 0);
        do_op(8'd9, 4'd2, 1'b0, q, r, dbz, lat);
        check("after_abort_q", q, 4);
        check("after_abort_r", r, 1);
        check("after_abort_lat", lat, 9);

        // Reset and in_valid together: divisor 0 would give out_valid next cycle if accepted
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.dividend = 8'd5;
        bus.divisor  = 4'd0;
        tick;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick;
        check("rst_wins_valid", bus.out_valid, 0);
        check("rst_wins_ready", bus.in_ready, 1);

        // Random operands including divide-by-zero, random result backpressure
        for (int i = 0; i < 60; i++) begin
            logic [7:0] n;
            logic [3:0] d;
            n = 8'($urandom);
            d = 4'($urandom_range(0, 15));
            model(n, d, mq, mr, mdbz);
            do_op(n, d, 1'b1, q, r, dbz, lat);
            check("rand_q", q, mq);
            check("rand_r", r, mr);
            check("rand_dbz", dbz, mdbz);
            check("rand_lat", lat, (d == 0) ? 1 : 9);
        end

        // Exhaustive nonzero-divisor sweep
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                do_op(8'(n), 4'(d), 1'b1, q, r, dbz, lat);
                check("sweep_recon", int'(q) * d + int'(r), n);
                check("sweep_r_lt_d", (int'(r) < d) ? 1 : 0, 1);
                check("sweep_lat", lat, 9);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
